stream_frame_sink: RTL and testbench
====================================

# stream_frame_sink

Receiving end of the 8-bit `data/valid/last` stream emitted by the example-processor pipeline stages. It captures one frame (bytes up to and including `in_last`) into an internal buffer, then replays that frame to a downstream consumer over a `valid/ready` handshake, such as a UART transmit front end. While a frame is held or draining, it reports `busy` so the controller can deassert the pipeline `enable`.

## Interface
- `DATA_WIDTH`, 8: byte width of the stream.
- `DEPTH`, 16: maximum stored frame length in bytes. Must be a power of two, ≥ 2.
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low (0 = reset), sampled on `clock`.
- `enable` in 1: input-side qualifier. Input bytes are sampled only when `enable` = 1.
- `in_data` in `DATA_WIDTH`: stream byte.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_last` in 1: final byte of the frame, qualified by `in_valid`.
- `out_data` out `DATA_WIDTH`: replayed byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts the byte when `out_valid` and `out_ready` are both 1.
- `out_last` out 1: the current `out_data` is the final byte of the frame.
- `frame_length` out `$clog2(DEPTH)+1`: number of stored bytes of the held frame.
- `frame_overflow` out 1: the held frame was truncated to `DEPTH` bytes.
- `dropped` out 1: sticky flag; set when an input byte arrives while not in FILL or TRUNC.
- `busy` out 1: high when state is not FILL.

## Operation
- **States:** FILL, TRUNC, DRAIN. Reset state is FILL.
- **Reset values:** `wr_ptr` = 0, `rd_ptr` = 0. All outputs are 0: `out_valid`, `out_last`, `frame_length`, `frame_overflow`, `dropped`, `busy`. Buffer contents are don't-care.
- **Input strobe:** a byte is "accepted" when `enable` && `in_valid`.
- **FILL, accepted byte:**
  - Write `mem[wr_ptr]` and increment `wr_ptr`.
  - If `in_last`: `frame_length` = `wr_ptr+1`, `frame_overflow` = 0, go to DRAIN.
  - Else, if this byte was number `DEPTH`: go to TRUNC.
- **TRUNC, accepted byte:** byte is discarded. On `in_last`: `frame_length` = `DEPTH`, `frame_overflow` = 1, go to DRAIN.
- **DRAIN:**
  - `out_valid` = 1 and `out_data` = `mem[rd_ptr]`.
  - `out_last` = (`rd_ptr` == `frame_length`−1).
  - On a handshake, `rd_ptr` increments.
  - A handshake with `out_last` set returns the block to FILL, with `wr_ptr` = 0 and `rd_ptr` = 0.
- **Input outside FILL/TRUNC:** any accepted byte in DRAIN is ignored and sets `dropped`. `dropped` clears only on reset.
- **`enable` = 0:** the input is not sampled and no state changes on the input side. DRAIN still progresses on `out_ready`.
- **Status hold:** `frame_length` and `frame_overflow` hold their values until the next frame completes.
- **Exact-fit frame:** `in_last` on byte number `DEPTH` yields `frame_length` = `DEPTH` and `frame_overflow` = 0.
- **Reset mid-frame or mid-drain:** the partial frame is abandoned and the next cycle is FILL with empty pointers.

## Timing
- **Capture to output:** if `in_last` is accepted in cycle N, `out_valid` = 1 in cycle N+1.
- **Throughput:** one byte per cycle in both directions.
- **Output stability:** `out_data`, `out_valid` and `out_last` hold while `out_valid` && !`out_ready`.
- **Return to FILL:** after the final handshake in cycle M, `out_valid` = 0 and `busy` = 0 in cycle M+1, and a byte presented in M+1 is accepted.
- **Output is registered state:** `out_data` is an asynchronous read of `mem[rd_ptr]`. `out_valid` and `out_last` depend only on registered state, with no combinational path from `out_ready`.

## Structure
- **Shared package/header:** state encodings `ST_FILL`, `ST_TRUNC`, `ST_DRAIN`, plus the pointer-width function (`$clog2(DEPTH)`).
- **Sub-module `frame_ram`:** `DEPTH` × `DATA_WIDTH` with one synchronous write port and one asynchronous read port.
- **Top level:** FSM, pointers and flags.

## Test plan
- **Single frame, consumer always ready:** frame 0x10, 0x20, 0x30 (last on 0x30), `out_ready` = 1 → outputs 0x10, 0x20, 0x30 on the 3 cycles after the last byte. `out_last` only with 0x30, `frame_length` = 3, `frame_overflow` = 0.
- **Backpressure:** same frame, `out_ready` toggling 1,0,0,1,1 → each byte is held stable while stalled, the order is preserved, and `busy` falls the cycle after 0x30 transfers.
- **Overflow:** with `DEPTH` = 16, a frame of 20 bytes 0x00..0x13 → 0x00..0x0F replayed, `out_last` on 0x0F, `frame_length` = 16, `frame_overflow` = 1.
- **Exact fit:** 16-byte frame → `frame_length` = 16, `frame_overflow` = 0.
- **Input during DRAIN and enable gating:**
  - A byte with `in_valid` during DRAIN → it is not stored and `dropped` = 1.
  - `enable` = 0 with `in_valid` = 1 in FILL → nothing is stored and `dropped` stays 0.
- **Reset mid-drain:** `reset` = 0 for one cycle halfway through replay → next cycle all outputs are 0 and the state is FILL. A new 2-byte frame then replays correctly.

Source files
------------

// File: rtl/stream_frame_sink_pkg.sv
// Shared definitions for the frame sink: FSM state encoding and pointer sizing.
package stream_frame_sink_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_TRUNC = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Frame buffer: one synchronous write port, one asynchronous read port.
// Zero-latency read; no flow control, contents are not reset.
module frame_ram
  import stream_frame_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                        i_clk,
  input  logic                        i_we,
  input  logic [ptr_width(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]       i_wdata,
  input  logic [ptr_width(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]       o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_frame_sink.sv
// Captures one frame (up to DEPTH bytes, excess discarded) then replays it over valid/ready.
// Replay starts the cycle after in_last; output stalls hold on !out_ready; input ignored while draining.
module stream_frame_sink
  import stream_frame_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [ptr_width(DEPTH):0] frame_length,
  output logic                      frame_overflow,
  output logic                      dropped,
  output logic                      busy
);

  localparam int AW = ptr_width(DEPTH);
  localparam logic [AW:0]   LEN_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  state_t            r_state;
  state_t            w_next;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_frame_len;
  logic              r_overflow;
  logic              r_dropped;

  logic                  w_accept;
  logic                  w_fill_wr;
  logic                  w_out_hs;
  logic                  w_rd_last;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_accept  = enable & in_valid;
  assign w_fill_wr = w_accept & (r_state == ST_FILL);
  assign w_out_hs  = (r_state == ST_DRAIN) & out_ready;
  assign w_rd_last = ({1'b0, r_rd_ptr} == (r_frame_len - (AW+1)'(1)));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_FILL: begin
        if (w_accept) begin
          if (in_last) begin
            w_next = ST_DRAIN;
          end else if (r_wr_ptr == PTR_LAST) begin
            w_next = ST_TRUNC;
          end
        end
      end
      ST_TRUNC: begin
        if (w_accept && in_last) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_out_hs && w_rd_last) begin
          w_next = ST_FILL;
        end
      end
      default: w_next = ST_FILL;
    endcase
  end

  // Write pointer wraps to 0 after byte DEPTH, so TRUNC needs no extra clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_frame_len <= '0;
      r_overflow  <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      if (w_fill_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_fill_wr && in_last) begin
        r_frame_len <= {1'b0, r_wr_ptr} + (AW+1)'(1);
        r_overflow  <= 1'b0;
      end
      if ((r_state == ST_TRUNC) && w_accept && in_last) begin
        r_frame_len <= LEN_FULL;
        r_overflow  <= 1'b1;
      end
      if (w_out_hs) begin
        if (w_rd_last) begin
          r_rd_ptr <= '0;
          r_wr_ptr <= '0;
        end else begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
      end
      if ((r_state == ST_DRAIN) && w_accept) begin
        r_dropped <= 1'b1;
      end
    end
  end

  frame_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_frame_ram (
    .i_clk  (clock),
    .i_we   (w_fill_wr),
    .i_waddr(r_wr_ptr),
    .i_wdata(in_data),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rd_data)
  );

  assign out_valid      = (r_state == ST_DRAIN);
  assign out_last       = out_valid & w_rd_last;
  assign out_data       = out_valid ? w_rd_data : '0;
  assign busy           = (r_state != ST_FILL);
  assign frame_length   = r_frame_len;
  assign frame_overflow = r_overflow;
  assign dropped        = r_dropped;

endmodule

// File: tb/tb_stream_frame_sink.sv
// Randomized self-checking bench for stream_frame_sink against a queue-based frame model.
module tb_stream_frame_sink;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic [LW-1:0] frame_length;
  logic          frame_overflow;
  logic          dropped;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] tx[$];
  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  bit            timed_out;
  int            drain_cycles;

  always #5 clock = ~clock;

  stream_frame_sink #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .frame_length  (frame_length),
    .frame_overflow(frame_overflow),
    .dropped       (dropped),
    .busy          (busy)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int stored_len();
    return (tx.size() > DEPTH) ? DEPTH : tx.size();
  endfunction

  // Optional idle cycles present bytes that must never be accepted.
  task automatic send_frame(input bit gaps);
    for (int i = 0; i < tx.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          enable   = 1'($urandom_range(1));
          in_valid = ~enable;
          in_data  = 8'($urandom);
          in_last  = 1'($urandom_range(1));
          step();
        end
      end
      enable   = 1'b1;
      in_valid = 1'b1;
      in_data  = tx[i];
      in_last  = (i == tx.size() - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input bit rand_ready, input int max_cycles);
    bit done;
    done = 1'b0;
    got_d.delete();
    got_l.delete();
    timed_out    = 1'b0;
    drain_cycles = 0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        if (out_last) begin
          done         = 1'b1;
          drain_cycles = c + 1;
        end
      end
      step();
    end
    out_ready = 1'b0;
    if (!done) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_out_last got %0b exp 0", out_last); end
    tests_run++; if (frame_length !== '0) begin tests_failed++; $display("FAIL reset_frame_length got %0d exp 0", frame_length); end
    tests_run++; if (frame_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %0b exp 0", frame_overflow); end
    tests_run++; if (dropped !== 1'b0) begin tests_failed++; $display("FAIL reset_dropped got %0b exp 0", dropped); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b exp 0", busy); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    tx = '{8'h10, 8'h20, 8'h30};
    send_frame(1'b0);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_latency got out_valid=%0b exp 1", out_valid); end
    tests_run++; if (frame_length !== LW'(3)) begin tests_failed++; $display("FAIL single_len got %0d exp 3", frame_length); end
    tests_run++; if (frame_overflow !== 1'b0) begin tests_failed++; $display("FAIL single_ovf got %0b exp 0", frame_overflow); end
    collect(1'b0, 20);
    tests_run++; if (drain_cycles !== 3) begin tests_failed++; $display("FAIL single_cycles got %0d exp 3", drain_cycles); end
    tests_run++; if (got_d.size() !== 3) begin tests_failed++; $display("FAIL single_count got %0d exp 3", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 3; i++) begin
      tests_run++; if (got_d[i] !== tx[i] || got_l[i] !== (i == 2)) begin tests_failed++; $display("FAIL single_byte%0d got %0h/%0b exp %0h/%0b", i, got_d[i], got_l[i], tx[i], (i == 2)); end
    end
    tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL single_return got valid=%0b busy=%0b exp 0/0", out_valid, busy); end
  endtask

  task automatic test_backpressure();
    bit pat[5];
    int idx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tx  = '{8'h10, 8'h20, 8'h30};
    send_frame(1'b0);
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      out_ready = pat[c];
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== tx[idx] || out_last !== (idx == 2)) begin
        tests_failed++;
        $display("FAIL bp_cycle%0d got v=%0b d=%0h l=%0b exp v=1 d=%0h l=%0b", c, out_valid, out_data, out_last, tx[idx], (idx == 2));
      end
      if (pat[c]) idx++;
      step();
    end
    out_ready = 1'b0;
    tests_run++; if (busy !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_return got busy=%0b valid=%0b exp 0/0", busy, out_valid); end
  endtask

  task automatic test_overflow();
    tx.delete();
    for (int i = 0; i < 20; i++) tx.push_back(8'(i));
    send_frame(1'b0);
    tests_run++; if (frame_length !== LW'(DEPTH)) begin tests_failed++; $display("FAIL ovf_len got %0d exp %0d", frame_length, DEPTH); end
    tests_run++; if (frame_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %0b exp 1", frame_overflow); end
    collect(1'b0, 40);
    tests_run++; if (got_d.size() !== DEPTH) begin tests_failed++; $display("FAIL ovf_count got %0d exp %0d", got_d.size(), DEPTH); end
    for (int i = 0; i < got_d.size() && i < DEPTH; i++) begin
      tests_run++; if (got_d[i] !== 8'(i) || got_l[i] !== (i == DEPTH - 1)) begin tests_failed++; $display("FAIL ovf_byte%0d got %0h/%0b exp %0h/%0b", i, got_d[i], got_l[i], i, (i == DEPTH - 1)); end
    end
  endtask

  task automatic test_exact_fit();
    tx.delete();
    for (int i = 0; i < DEPTH; i++) tx.push_back(8'($urandom));
    send_frame(1'b0);
    tests_run++; if (frame_length !== LW'(DEPTH)) begin tests_failed++; $display("FAIL fit_len got %0d exp %0d", frame_length, DEPTH); end
    tests_run++; if (frame_overflow !== 1'b0) begin tests_failed++; $display("FAIL fit_flag got %0b exp 0", frame_overflow); end
    collect(1'b1, 300);
    tests_run++; if (timed_out !== 1'b0 || got_d.size() !== DEPTH) begin tests_failed++; $display("FAIL fit_count got %0d timeout=%0b exp %0d", got_d.size(), timed_out, DEPTH); end
    for (int i = 0; i < got_d.size() && i < DEPTH; i++) begin
      tests_run++; if (got_d[i] !== tx[i]) begin tests_failed++; $display("FAIL fit_byte%0d got %0h exp %0h", i, got_d[i], tx[i]); end
    end
  endtask

  task automatic test_drop_and_enable();
    enable   = 1'b0;
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 8'hAA;
    step();
    step();
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests_run++; if (busy !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL gate_state got busy=%0b valid=%0b exp 0/0", busy, out_valid); end
    tests_run++; if (dropped !== 1'b0) begin tests_failed++; $display("FAIL gate_dropped got %0b exp 0", dropped); end
    tx = '{8'h5A, 8'hA5};
    send_frame(1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_data   = 8'hFF;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests_run++; if (dropped !== 1'b1) begin tests_failed++; $display("FAIL drop_flag got %0b exp 1", dropped); end
    tests_run++; if (frame_length !== LW'(2) || out_data !== 8'h5A) begin tests_failed++; $display("FAIL drop_hold got len=%0d d=%0h exp 2/5a", frame_length, out_data); end
    enable = 1'b0;
    collect(1'b0, 20);
    enable = 1'b1;
    tests_run++; if (got_d.size() !== 2) begin tests_failed++; $display("FAIL drop_count got %0d exp 2", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 2; i++) begin
      tests_run++; if (got_d[i] !== tx[i]) begin tests_failed++; $display("FAIL drop_byte%0d got %0h exp %0h", i, got_d[i], tx[i]); end
    end
    tests_run++; if (dropped !== 1'b1) begin tests_failed++; $display("FAIL drop_sticky got %0b exp 1", dropped); end
  endtask

  task automatic test_reset_mid_drain();
    tx.delete();
    for (int i = 0; i < 6; i++) tx.push_back(8'($urandom));
    send_frame(1'b0);
    out_ready = 1'b1;
    step();
    step();
    step();
    out_ready = 1'b0;
    reset     = 1'b0;
    step();
    tests_run++; if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_state got v=%0b l=%0b busy=%0b exp 0/0/0", out_valid, out_last, busy); end
    tests_run++; if (frame_length !== '0 || frame_overflow !== 1'b0 || dropped !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_flags got len=%0d ovf=%0b drop=%0b exp 0/0/0", frame_length, frame_overflow, dropped); end
    reset = 1'b1;
    tx = '{8'hC3, 8'h3C};
    send_frame(1'b0);
    tests_run++; if (frame_length !== LW'(2)) begin tests_failed++; $display("FAIL mid_reset_len got %0d exp 2", frame_length); end
    collect(1'b0, 20);
    tests_run++; if (got_d.size() !== 2) begin tests_failed++; $display("FAIL mid_reset_count got %0d exp 2", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 2; i++) begin
      tests_run++; if (got_d[i] !== tx[i] || got_l[i] !== (i == 1)) begin tests_failed++; $display("FAIL mid_reset_byte%0d got %0h/%0b exp %0h/%0b", i, got_d[i], got_l[i], tx[i], (i == 1)); end
    end
  endtask

  // Frames go back to back: each new frame starts in the cycle right after the previous drain.
  task automatic test_random_frames();
    int n;
    for (int f = 0; f < 25; f++) begin
      tx.delete();
      n = $urandom_range(24, 1);
      for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
      send_frame(1'b1);
      n = stored_len();
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rnd%0d_latency got %0b exp 1", f, out_valid); end
      tests_run++; if (frame_length !== LW'(n) || frame_overflow !== (tx.size() > DEPTH)) begin tests_failed++; $display("FAIL rnd%0d_status got len=%0d ovf=%0b exp %0d/%0b", f, frame_length, frame_overflow, n, (tx.size() > DEPTH)); end
      collect(1'b1, 400);
      tests_run++; if (timed_out !== 1'b0 || got_d.size() !== n) begin tests_failed++; $display("FAIL rnd%0d_count got %0d timeout=%0b exp %0d", f, got_d.size(), timed_out, n); end
      for (int i = 0; i < got_d.size() && i < n; i++) begin
        tests_run++; if (got_d[i] !== tx[i] || got_l[i] !== (i == n - 1)) begin tests_failed++; $display("FAIL rnd%0d_byte%0d got %0h/%0b exp %0h/%0b", f, i, got_d[i], got_l[i], tx[i], (i == n - 1)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_overflow();
    test_exact_fit();
    test_drop_and_enable();
    test_reset_mid_drain();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
